// File: rtl/sisc_dmem.sv
// sisc_dmem -- data-memory responder for the SISC load/store path.
//
// Accepts one LOD/STR/SWP request at a time over a ready/req handshake.
// Before the access it inserts WAIT wait states. It then performs a read,
// write or atomic swap on an internal single-port array. Completion is
// signalled with a one-cycle ack pulse that carries registered read data.
//
// Parameters:
//   ADDR_W  word-address width (array depth 2**ADDR_W)
//   DATA_W  data word width
//   WAIT    wait states before the access, 0..15
//
// Ports:
//   clk    in   rising-edge clock
//   rst_f  in   asynchronous active-high reset
//   req    in   request valid, sampled only while ready=1
//   op     in   00 read, 01 write, 10 swap, 11 reserved
//   addr   in   word address
//   wdata  in   store/swap data
//   ready  out  idle and able to accept a request
//   ack    out  one-cycle completion pulse
//   rdata  out  read/swap result, held until the next read/swap completes
//   err    out  high with ack when the completed op was reserved
module sisc_dmem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);
  localparam int         DEPTH    = 1 << ADDR_W;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // Request fields captured at accept; inputs are ignored afterwards.
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [DATA_W-1:0]   mem_rd;

  assign mem_rd = mem[addr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // ready_q gates acceptance so the cycle right after reset release
        // only raises ready and never takes a request.
        ready_d = 1'b1;
        if (ready_q && req) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          ready_d = 1'b0;
          cnt_d   = WAIT_CNT;
          state_d = (WAIT_CNT == 4'd0) ? S_ACCESS : S_WAIT;
        end
      end

      S_WAIT: begin
        // Leave on the edge where the counter reaches zero, so the access
        // starts exactly WAIT edges after the accept.
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        // A swap reads the old word and writes the new one on the same edge.
        case (op_q)
          OP_READ:  rdata_d = mem_rd;
          OP_WRITE: mem_we  = 1'b1;
          OP_SWAP: begin
            rdata_d = mem_rd;
            mem_we  = 1'b1;
          end
          default:  err_d   = 1'b1;
        endcase
        ack_d   = 1'b1;
        state_d = S_RESP;
      end

      S_RESP: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // The request latches need no reset: they are only consumed after an
  // accept has refreshed them.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // The array is not cleared by reset. Reset forces S_IDLE, so an op that
  // has not passed its access edge never writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign ready = ready_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_sisc_dmem.sv
// Bench for sisc_dmem: three instances (WAIT = 2, 0, 15) driven one at a
// time against an array-based reference model of the memory contents and
// of the held read-data register.
module tb_sisc_dmem;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_f;
  logic [NI-1:0]         req_v;
  logic [NI-1:0][1:0]    op_v;
  logic [NI-1:0][7:0]    addr_v;
  logic [NI-1:0][31:0]   wdata_v;
  logic [NI-1:0]         ready_v;
  logic [NI-1:0]         ack_v;
  logic [NI-1:0]         err_v;
  logic [NI-1:0][31:0]   rdata_v;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sisc_dmem #(
      .ADDR_W(8),
      .DATA_W(32),
      .WAIT  (g == 0 ? 2 : (g == 1 ? 0 : 15))
    ) u_dut (
      .clk  (clk),
      .rst_f(rst_f),
      .req  (req_v[g]),
      .op   (op_v[g]),
      .addr (addr_v[g]),
      .wdata(wdata_v[g]),
      .ready(ready_v[g]),
      .ack  (ack_v[g]),
      .rdata(rdata_v[g]),
      .err  (err_v[g])
    );
  end

  function automatic int wt(int i);
    return (i == 0) ? 2 : ((i == 1) ? 0 : 15);
  endfunction

  int vectors     = 0;
  int miscompares = 0;

  // Model: addresses used are confined to 0..63 and written before use.
  logic [31:0] mdl_mem [NI][64];
  logic [31:0] mdl_rd  [NI];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic scramble(input int i);
    op_v[i]    = 2'($urandom);
    addr_v[i]  = 8'($urandom);
    wdata_v[i] = $urandom;
  endtask

  task automatic wait_ready(input int i);
    int k;
    k = 0;
    while (!ready_v[i] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ready_v[i]) check($sformatf("ready_timeout[%0d]", i), 32'(ready_v[i]), 32'd1);
  endtask

  // One full transaction, sampled on negedges. Cycle k is the cycle that
  // follows edge E0+k, E0 being the accept edge.
  task automatic do_op(input int i, input logic [1:0] o, input logic [7:0] a, input logic [31:0] d);
    int          kack, rlow, bad_err;
    logic [31:0] exp_rd;
    logic        exp_err;
    wait_ready(i);
    req_v[i] = 1'b1; op_v[i] = o; addr_v[i] = a; wdata_v[i] = d;

    exp_rd  = mdl_rd[i];
    exp_err = 1'b0;
    case (o)
      2'b00: exp_rd = mdl_mem[i][a[5:0]];
      2'b01: mdl_mem[i][a[5:0]] = d;
      2'b10: begin
        exp_rd = mdl_mem[i][a[5:0]];
        mdl_mem[i][a[5:0]] = d;
      end
      default: exp_err = 1'b1;
    endcase

    @(posedge clk);
    @(negedge clk);
    req_v[i] = 1'b0;
    kack = -1; rlow = 0; bad_err = 0;
    for (int kk = 0; kk < 40 && kack < 0; kk++) begin
      if (!ready_v[i]) rlow++;
      if (ack_v[i]) kack = kk;
      else begin
        if (err_v[i]) bad_err++;
        scramble(i);
        @(negedge clk);
      end
    end
    check($sformatf("latency[%0d] op%0d", i, o), 32'(kack), 32'(wt(i) + 1));
    check($sformatf("rdata[%0d] op%0d a%0h", i, o, a), rdata_v[i], exp_rd);
    check($sformatf("err[%0d] op%0d", i, o), 32'(err_v[i]), 32'(exp_err));
    check($sformatf("err_outside_ack[%0d]", i), 32'(bad_err), 32'd0);
    @(negedge clk);
    if (!ready_v[i]) rlow++;
    check($sformatf("ack_pulse[%0d]", i), 32'(ack_v[i]), 32'd0);
    check($sformatf("err_clear[%0d]", i), 32'(err_v[i]), 32'd0);
    check($sformatf("ready_low[%0d]", i), 32'(rlow), 32'(wt(i) + 2));
    mdl_rd[i] = exp_rd;
  endtask

  // Write accepted, then reset asserted before the access completes.
  task automatic reset_mid_write(input int i);
    int acks;
    wait_ready(i);
    req_v[i] = 1'b1; op_v[i] = 2'b01; addr_v[i] = 8'h20; wdata_v[i] = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_v[i] = 1'b0;
    rst_f = 1'b1;
    acks = 0;
    repeat (2) begin
      scramble(i);
      @(negedge clk);
      if (ack_v[i]) acks++;
    end
    rst_f = 1'b0;
    repeat (wt(i) + 4) begin
      @(negedge clk);
      if (ack_v[i]) acks++;
    end
    check($sformatf("reset_mid_no_ack[%0d]", i), 32'(acks), 32'd0);
    for (int j = 0; j < NI; j++) mdl_rd[j] = 32'h0;
    do_op(i, 2'b00, 8'h20, 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_f = 1'b1;
    req_v = '0; op_v = '0; addr_v = '0; wdata_v = '0;
    for (int j = 0; j < NI; j++) mdl_rd[j] = 32'h0;

    repeat (3) begin
      @(negedge clk);
      for (int j = 0; j < NI; j++) begin
        check($sformatf("rst_ready[%0d]", j), 32'(ready_v[j]), 32'd0);
        check($sformatf("rst_ack[%0d]", j),   32'(ack_v[j]),   32'd0);
        check($sformatf("rst_err[%0d]", j),   32'(err_v[j]),   32'd0);
        check($sformatf("rst_rdata[%0d]", j), rdata_v[j],      32'd0);
      end
    end
    rst_f = 1'b0;
    #1;
    for (int j = 0; j < NI; j++)
      check($sformatf("ready_before_edge[%0d]", j), 32'(ready_v[j]), 32'd0);
    @(negedge clk);
    for (int j = 0; j < NI; j++)
      check($sformatf("ready_after_release[%0d]", j), 32'(ready_v[j]), 32'd1);

    for (int i = 0; i < NI; i++) begin
      for (int a = 0; a < 64; a++) do_op(i, 2'b01, 8'(a), $urandom);
      do_op(i, 2'b01, 8'h10, 32'hDEADBEEF);
      do_op(i, 2'b00, 8'h10, 32'h0);
      do_op(i, 2'b01, 8'h05, 32'h00000011);
      do_op(i, 2'b10, 8'h05, 32'h00000022);
      do_op(i, 2'b00, 8'h05, 32'h0);
      do_op(i, 2'b11, 8'h05, 32'h00000099);
      do_op(i, 2'b00, 8'h05, 32'h0);
      repeat (40) do_op(i, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 63)), $urandom);
    end

    for (int i = 0; i < NI; i++) begin
      do_op(i, 2'b01, 8'h20, 32'h00000001);
      reset_mid_write(i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sisc_dmem.md
# sisc_dmem

Data-memory responder for the SISC processor: the target end of the load/store request interface driven by the control/datapath side for LOD, STR and SWP. It accepts one request at a time over a ready/req handshake, inserts a configurable number of wait states, and performs the read, write or atomic swap on an internal single-port array. It returns completion on a one-cycle `ack` pulse with registered read data.

## Interface
- `ADDR_W`, 8: word-address width; array depth is 2^ADDR_W words.
- `DATA_W`, 32: data word width.
- `WAIT`, 2: wait states inserted before the access; legal range 0..15.

- `clk`  in  1  system clock, rising edge.
- `rst_f`  in  1  asynchronous, active-high reset.
- `req`  in  1  request valid; sampled only when `ready`=1.
- `op`  in  2  00 read, 01 write, 10 swap, 11 reserved.
- `addr`  in  ADDR_W  word address.
- `wdata`  in  DATA_W  store/swap data.
- `ready`  out  1  block idle and able to accept a request.
- `ack`  out  1  one-cycle completion pulse.
- `rdata`  out  DATA_W  read/swap result; valid while `ack`=1, held until the next read/swap completes.
- `err`  out  1  asserted with `ack` when the completed op was reserved.

## Operation
- States: IDLE, WAIT, ACCESS, RESP. All outputs registered.
- Reset (async, `rst_f`=1): state IDLE, `ready`=0 while reset is held, `ack`=0, `err`=0, `rdata`=0, wait counter 0. Array contents are not cleared. First clock edge after release sets `ready`=1.
- IDLE: `ready`=1. On `req`=1, latch `op`, `addr` and `wdata`, and drop `ready`. Go to WAIT with counter=WAIT. If WAIT=0, go directly to ACCESS.
- WAIT: counter decrements each cycle. On the edge where the counter reaches 0, go to ACCESS. `req`/`op`/`addr`/`wdata` changes are ignored; only latched values are used.
- ACCESS, one cycle. On its closing edge:
  - read: `rdata` <= mem[addr].
  - write: mem[addr] <= wdata; `rdata` unchanged.
  - swap: `rdata` <= old mem[addr] and mem[addr] <= wdata on the same edge. Atomic; no other request can intervene.
  - reserved: no array or `rdata` change; `err` <= 1.
  - Then go to RESP.
- RESP, one cycle: `ack`=1 and `err` valid. The next edge clears `ack` and `err`, sets `ready`=1, and returns to IDLE.
- `err` is never high outside an `ack` cycle.
- Address arithmetic: none. `addr` is used directly and always in range by construction.

## Timing
- Request accepted at edge E0 (`req`=1 and `ready`=1).
- ACCESS is entered at edge E0+WAIT. The array update and `rdata` update happen at E0+WAIT+1.
- `ack` is high for the cycle between E0+WAIT+1 and E0+WAIT+2.
- `ready`=1 after E0+WAIT+2. The earliest next accept is E0+WAIT+3, giving throughput of one op per WAIT+3 cycles.
- Back-to-back write then read of the same address returns the newly written value; there is no bypass hazard because the ops are serialized.
- Reset mid-operation: any op not past its ACCESS closing edge is dropped with no array write. A pending `ack` is cancelled.
- `req` held high continuously is treated as a new request at each IDLE cycle. The requester must deassert `req` after acceptance to avoid a repeat.

## Test plan
- Reset then idle: assert `rst_f` for 3 cycles → `ready`=0, `ack`=0, `rdata`=0, `err`=0 during reset; `ready`=1 one edge after release.
- Write/read, WAIT=2: write 0xDEADBEEF to addr 0x10, then read 0x10 → each `ack` occurs exactly 3 cycles after its accept edge; the read's `rdata`=0xDEADBEEF and `err`=0.
- Swap: with mem[0x05]=0x00000011, swap with wdata 0x00000022 → `rdata`=0x00000011 at `ack`; a following read of 0x05 returns 0x00000022.
- Reserved op 11 at addr 0x05 → `err`=1 only during the `ack` cycle; mem[0x05] and `rdata` unchanged.
- WAIT=0 and WAIT=15 builds: measure accept-to-`ack` at 1 and 16 cycles; `ready` low for 2 and 17 cycles respectively. Inputs changed during WAIT have no effect.
- Reset mid-op: issue a write of 0xCAFEF00D to 0x20 (prior value 0x1), assert reset during WAIT → no `ack`; a later read of 0x20 returns 0x1.
